// File: rtl/aqed_fifo_pkg.sv
// Shared types, defaults and the logical-depth clamp for the A-QED golden
// FIFO responder.
package aqed_fifo_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int MAX_DEPTH  = 64;
  localparam int CNT_WIDTH  = $clog2(MAX_DEPTH + 1);

  typedef logic [DATA_WIDTH-1:0] data_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;

  // A depth of zero or one beyond the physical array selects the full array.
  function automatic int unsigned eff_depth_f(input logic [15:0] depth,
                                              input int unsigned max_depth);
    int unsigned d;
    d = {16'b0, depth};
    if (d == 0 || d > max_depth) begin
      return max_depth;
    end
    return d;
  endfunction

endpackage

// File: rtl/aqed_fifo_storage.sv
// 1W1R register array backing the FIFO responder. The read port is
// combinational; the caller registers the returned word.
module aqed_fifo_storage #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write port: one entry per accepted write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: asynchronous lookup.
  always_comb begin
    rdata = mem[raddr];
  end

endmodule

// File: rtl/aqed_fifo_responder.sv
// Golden FIFO-mode responder for the A-QED memory-controller harness.
// Optional macro AQED_FIFO_ERR_FLAG_EN adds sticky overflow_err/underflow_err.
//
// Request semantics: wen_in/ren_in are fire-and-forget requests with no
// ready back-pressure. A read is accepted when clk_en & ren_in & !empty and
// its word appears on data_out with valid_out=1 on the following edge. A
// write is accepted when clk_en & wen_in & (!full | read accepted); any
// other request is silently dropped (or flagged when error flags exist).
module aqed_fifo_responder
  import aqed_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = aqed_fifo_pkg::DATA_WIDTH,
  parameter int MAX_DEPTH  = aqed_fifo_pkg::MAX_DEPTH,
  parameter int CNT_WIDTH  = $clog2(MAX_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic                  flush,
  input  logic [15:0]           depth,
  input  logic [3:0]            almost_count,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wen_in,
  input  logic                  ren_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_WIDTH-1:0]  occupancy
`ifdef AQED_FIFO_ERR_FLAG_EN
  ,
  output logic                  overflow_err,
  output logic                  underflow_err
`endif
);

  localparam int PTR_W = $clog2(MAX_DEPTH);
  localparam int CMP_W = (CNT_WIDTH > 4) ? CNT_WIDTH : 4;

  logic [PTR_W-1:0]      rd_ptr, wr_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [CNT_WIDTH-1:0]  occ_q, eff_depth_q, last_idx;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_acc, wr_acc, clear;
  logic [CMP_W-1:0]      occ_ext, eff_ext, ac_ext, af_thresh;

  assign clear     = !reset || flush;
  assign occupancy = occ_q;

  // Acceptance qualifiers and modulo-eff_depth pointer increments.
  always_comb begin
    rd_acc     = clk_en && ren_in && !empty;
    wr_acc     = clk_en && wen_in && (!full || rd_acc);
    last_idx   = eff_depth_q - CNT_WIDTH'(1);
    rd_ptr_nxt = (CNT_WIDTH'(rd_ptr) == last_idx) ? '0 : rd_ptr + PTR_W'(1);
    wr_ptr_nxt = (CNT_WIDTH'(wr_ptr) == last_idx) ? '0 : wr_ptr + PTR_W'(1);
  end

  aqed_fifo_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (MAX_DEPTH),
    .ADDR_W     (PTR_W)
  ) u_storage (
    .clk   (clk),
    .we    (wr_acc && !clear),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  // Pointer, occupancy, depth latch and registered read output.
  always_ff @(posedge clk) begin
    if (clear) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ_q       <= '0;
      data_out    <= '0;
      valid_out   <= 1'b0;
      eff_depth_q <= CNT_WIDTH'(eff_depth_f(depth, MAX_DEPTH));
    end else if (clk_en) begin
      valid_out <= rd_acc;
      if (rd_acc) begin
        data_out <= rd_data;
        rd_ptr   <= rd_ptr_nxt;
      end
      if (wr_acc) begin
        wr_ptr <= wr_ptr_nxt;
      end
      case ({wr_acc, rd_acc})
        2'b10:   occ_q <= occ_q + CNT_WIDTH'(1);
        2'b01:   occ_q <= occ_q - CNT_WIDTH'(1);
        default: occ_q <= occ_q;
      endcase
    end else begin
      valid_out <= 1'b0;
    end
  end

  // Status flags; the almost_full threshold saturates at zero.
  always_comb begin
    occ_ext      = CMP_W'(occ_q);
    eff_ext      = CMP_W'(eff_depth_q);
    ac_ext       = CMP_W'(almost_count);
    af_thresh    = (ac_ext >= eff_ext) ? '0 : eff_ext - ac_ext;
    empty        = (occ_q == '0);
    full         = (occ_q == eff_depth_q);
    almost_full  = (occ_ext >= af_thresh);
    almost_empty = (occ_ext <= ac_ext);
  end

`ifdef AQED_FIFO_ERR_FLAG_EN
  // Sticky error flags for dropped writes and reads of an empty FIFO.
  always_ff @(posedge clk) begin
    if (clear) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (clk_en && wen_in && full && !rd_acc) begin
        overflow_err <= 1'b1;
      end
      if (clk_en && ren_in && empty) begin
        underflow_err <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: doc/aqed_fifo_responder.md
Name: aqed_fifo_responder

Overview:
Golden FIFO-mode responder for the A-QED memory-controller harness. It sits on the far side of the A-QED initiator's write/read stream and accepts the same data_in/wen_in/ren_in traffic the memory core accepts in FIFO mode. It returns data_out/valid_out with the memory core's FIFO timing, plus status flags. It serves as a drop-in reference responder for self-consistency checks and for bring-up of the A-QED checker without the full memory core.

Parameters:
DATA_WIDTH, 16, width of stored words
MAX_DEPTH, 64, physical entries; any integer >= 2
CNT_WIDTH, $clog2(MAX_DEPTH+1), width of occupancy counter

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-low reset
clk_en  input  1  global clock enable; state advances only when high (flush excepted)
flush  input  1  synchronous clear of FIFO contents
depth  input  16  configured logical depth; latched at reset and on flush
almost_count  input  4  almost_full/almost_empty threshold
data_in  input  DATA_WIDTH  write data
wen_in  input  1  write request
ren_in  input  1  read request
data_out  output  DATA_WIDTH  read data, registered
valid_out  output  1  data_out valid, one-cycle pulse per accepted read
full  output  1  occupancy == eff_depth
empty  output  1  occupancy == 0
almost_full  output  1  occupancy >= eff_depth - almost_count (saturating at 0)
almost_empty  output  1  occupancy <= almost_count
occupancy  output  CNT_WIDTH  current entry count

Behaviour:
- Reset (reset==0 at clk edge):
  - rd_ptr, wr_ptr, occupancy = 0; data_out = 0; valid_out = 0.
  - eff_depth latched from depth.
  - Resulting flags: empty=1, full=0, almost_empty=1; almost_full=1 only if almost_count >= eff_depth.
  - Reset overrides flush, clk_en and all requests, including mid-transfer.
- eff_depth rule:
  - depth==0 or depth>MAX_DEPTH -> MAX_DEPTH; otherwise depth.
  - Changes to depth between reset/flush events are ignored.
- flush==1 (reset inactive):
  - Same clears as reset and re-latches depth, regardless of clk_en.
  - Concurrent wen_in/ren_in are dropped.
- clk_en==0:
  - Pointers, occupancy and data_out hold.
  - valid_out registers 0.
- Read acceptance: rd_acc = clk_en & ren_in & !empty.
  - Latency 1: on the edge after acceptance, data_out = mem[rd_ptr] and valid_out = 1.
  - rd_ptr advances.
- Read of empty FIFO: ignored, valid_out=0, data_out holds. There is no write-to-read bypass.
- Write acceptance: wr_acc = clk_en & wen_in & (!full | rd_acc).
  - Full FIFO with simultaneous accepted read: write is accepted and occupancy stays eff_depth.
  - Full FIFO without a read: write is dropped.
- Pointer wrap: each pointer increments modulo eff_depth (eff_depth-1 -> 0). Non-power-of-two depths are legal.
- Occupancy update:
  - +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
  - Never exceeds eff_depth and never underflows.
- Flags are combinational from occupancy, eff_depth and almost_count.
- Ordering: strict FIFO; the Nth accepted write is returned on the Nth valid_out pulse.

Optional Feature:
Macro: AQED_FIFO_ERR_FLAG_EN
- Defined:
  - Adds outputs overflow_err and underflow_err (1 bit each).
  - overflow_err sets sticky on a dropped write (clk_en & wen_in & full & !rd_acc).
  - underflow_err sets sticky on clk_en & ren_in & empty.
  - Both clear only on reset or flush.
- Undefined: ports are absent and dropped requests are silent.

Decomposition:
- Package aqed_fifo_pkg:
  - DATA_WIDTH default, typedefs data_t and cnt_t.
  - Function eff_depth_f(depth, MAX_DEPTH) implementing the clamp rule.
- Sub-module aqed_fifo_storage:
  - Parameterised 1W1R register array: write port (we, waddr, wdata), read port (raddr, rdata combinational).
  - Top level owns pointers, counters, flags and the output register.

Test Plan:
- depth=4, almost_count=1; write 0x11,0x22,0x33,0x44 -> full=1, almost_full=1 after 3rd write. 5th write 0x55 is dropped; reads return 0x11..0x44 on four valid_out pulses, each one cycle after its ren_in. Then empty=1.
- depth=3 (non-power-of-two); 10 interleaved write/read pairs 0x100..0x109 -> pointers wrap 2->0, data returned in order, occupancy never exceeds 3.
- Full FIFO (depth=2), wen_in=ren_in=1 same cycle with data 0xBEEF -> occupancy stays 2, oldest word is output, 0xBEEF is returned two reads later.
- Empty FIFO, wen_in=ren_in=1 with 0x0A0A -> valid_out=0 next cycle, occupancy=1. Next ren_in returns 0x0A0A.
- Occupancy 3, clk_en=0 for 5 cycles with ren_in=1 -> no valid_out, occupancy=3. Then flush=1 with clk_en=0 -> occupancy=0, empty=1. depth changed 4->8 takes effect only after the flush.
- reset=0 asserted mid-burst (occupancy 2, read in flight) -> next cycle valid_out=0, data_out=0, empty=1. With AQED_FIFO_ERR_FLAG_EN, a read on empty afterwards sets underflow_err=1, which holds until flush.
